// File: rtl/mic1_pkg.sv
// Shared definitions for the Mic-1 C-bus register file: default width, B-bus
// source encodings and C-bus write-enable bit positions.
package mic1_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned NumCRegs     = 9;
  localparam int unsigned MbrWidth     = 8;

  // C_SEL bit positions
  localparam int unsigned CSelMar = 0;
  localparam int unsigned CSelMdr = 1;
  localparam int unsigned CSelPc  = 2;
  localparam int unsigned CSelSp  = 3;
  localparam int unsigned CSelLv  = 4;
  localparam int unsigned CSelCpp = 5;
  localparam int unsigned CSelTos = 6;
  localparam int unsigned CSelOpc = 7;
  localparam int unsigned CSelH   = 8;

  typedef enum logic [3:0] {
    BSelMdr  = 4'd0,
    BSelPc   = 4'd1,
    BSelMbrS = 4'd2,
    BSelMbrU = 4'd3,
    BSelSp   = 4'd4,
    BSelLv   = 4'd5,
    BSelCpp  = 4'd6,
    BSelTos  = 4'd7,
    BSelOpc  = 4'd8
  } b_sel_e;

endpackage

// File: rtl/b_bus_mux.sv
// Combinational B-bus source selector; unused encodings drive zero.
module b_bus_mux
  import mic1_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [3:0]          b_sel,
  input  logic [WIDTH-1:0]    mdr,
  input  logic [WIDTH-1:0]    pc,
  input  logic [MbrWidth-1:0] mbr,
  input  logic [WIDTH-1:0]    sp,
  input  logic [WIDTH-1:0]    lv,
  input  logic [WIDTH-1:0]    cpp,
  input  logic [WIDTH-1:0]    tos,
  input  logic [WIDTH-1:0]    opc,
  output logic [WIDTH-1:0]    b_out
);

  b_sel_e sel;

  always_comb begin
    sel   = b_sel_e'(b_sel);
    b_out = '0;
    case (sel)
      BSelMdr:  b_out = mdr;
      BSelPc:   b_out = pc;
      BSelMbrS: b_out = {{(WIDTH-MbrWidth){mbr[MbrWidth-1]}}, mbr};
      BSelMbrU: b_out = {{(WIDTH-MbrWidth){1'b0}}, mbr};
      BSelSp:   b_out = sp;
      BSelLv:   b_out = lv;
      BSelCpp:  b_out = cpp;
      BSelTos:  b_out = tos;
      BSelOpc:  b_out = opc;
      default:  b_out = '0;
    endcase
  end

endmodule

// File: rtl/c_bus_regfile.sv
// Mic-1 register file: C-bus writeback, memory command staging with one-cycle
// read/fetch return into MDR/MBR, latched ALU flags and B-bus selection.
module c_bus_regfile
  import mic1_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [WIDTH-1:0]    Shift,
  input  logic [8:0]          C_SEL,
  input  logic [3:0]          B_SEL,
  input  logic                ALU_N,
  input  logic                ALU_Z,
  input  logic                RD,
  input  logic                WR,
  input  logic                FETCH,
  input  logic [WIDTH-1:0]    MEM_RDATA,
  input  logic [MbrWidth-1:0] MEM_BDATA,
  output logic [WIDTH-1:0]    A_out,
  output logic [WIDTH-1:0]    B_out,
  output logic                N_FLAG,
  output logic                Z_FLAG,
  output logic [WIDTH-1:0]    MEM_ADDR,
  output logic [WIDTH-1:0]    FETCH_ADDR,
  output logic [WIDTH-1:0]    MEM_WDATA,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic                MEM_FETCH,
  output logic                MDR_CONFLICT
);

  logic [WIDTH-1:0]    creg_q [NumCRegs];
  logic [MbrWidth-1:0] mbr_q;
  logic                n_q, z_q;
  logic                mem_rd_q, mem_wr_q, mem_fetch_q;
  logic                conflict_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NumCRegs; i++) creg_q[i] <= '0;
      mbr_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_fetch_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NumCRegs; i++) begin
        if (C_SEL[i]) creg_q[i] <= Shift;
      end
      // Returning read data overrides a same-cycle C-bus write to MDR.
      if (mem_rd_q) creg_q[CSelMdr] <= MEM_RDATA;
      if (mem_fetch_q) mbr_q <= MEM_BDATA;
      n_q         <= ALU_N;
      z_q         <= ALU_Z;
      mem_rd_q    <= RD;
      mem_wr_q    <= WR;
      mem_fetch_q <= FETCH;
      conflict_q  <= mem_rd_q & C_SEL[CSelMdr];
    end
  end

  assign A_out        = creg_q[CSelH];
  assign MEM_ADDR     = creg_q[CSelMar];
  assign FETCH_ADDR   = creg_q[CSelPc];
  assign MEM_WDATA    = creg_q[CSelMdr];
  assign N_FLAG       = n_q;
  assign Z_FLAG       = z_q;
  assign MEM_RD       = mem_rd_q;
  assign MEM_WR       = mem_wr_q;
  assign MEM_FETCH    = mem_fetch_q;
  assign MDR_CONFLICT = conflict_q;

  b_bus_mux #(
    .WIDTH(WIDTH)
  ) u_b_bus_mux (
    .b_sel(B_SEL),
    .mdr  (creg_q[CSelMdr]),
    .pc   (creg_q[CSelPc]),
    .mbr  (mbr_q),
    .sp   (creg_q[CSelSp]),
    .lv   (creg_q[CSelLv]),
    .cpp  (creg_q[CSelCpp]),
    .tos  (creg_q[CSelTos]),
    .opc  (creg_q[CSelOpc]),
    .b_out(B_out)
  );

endmodule

// File: tb/tb_c_bus_regfile.sv
// Self-checking bench for c_bus_regfile: directed scenarios plus a randomized
// run against a register-name-level reference model.
module tb_c_bus_regfile;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] Shift;
  logic [8:0]  C_SEL;
  logic [3:0]  B_SEL;
  logic        ALU_N, ALU_Z, RD, WR, FETCH;
  logic [31:0] MEM_RDATA;
  logic [7:0]  MEM_BDATA;
  logic [31:0] A_out, B_out, MEM_ADDR, FETCH_ADDR, MEM_WDATA;
  logic        N_FLAG, Z_FLAG, MEM_RD, MEM_WR, MEM_FETCH, MDR_CONFLICT;

  int n_cmp = 0;
  int n_err = 0;

  c_bus_regfile #(.WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Shift(Shift), .C_SEL(C_SEL), .B_SEL(B_SEL),
    .ALU_N(ALU_N), .ALU_Z(ALU_Z), .RD(RD), .WR(WR), .FETCH(FETCH),
    .MEM_RDATA(MEM_RDATA), .MEM_BDATA(MEM_BDATA), .A_out(A_out), .B_out(B_out),
    .N_FLAG(N_FLAG), .Z_FLAG(Z_FLAG), .MEM_ADDR(MEM_ADDR), .FETCH_ADDR(FETCH_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_FETCH(MEM_FETCH),
    .MDR_CONFLICT(MDR_CONFLICT)
  );

  always #5 CLK = ~CLK;

  // Reference state keyed by register name
  logic [31:0] m_mar, m_mdr, m_pc, m_sp, m_lv, m_cpp, m_tos, m_opc, m_h;
  logic [7:0]  m_mbr;
  logic        m_n, m_z, m_conf;
  logic [2:0]  pend_cmd; // {fetch, wr, rd} issued last cycle

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Shift = '0; C_SEL = '0; B_SEL = '0; ALU_N = 0; ALU_Z = 0;
    RD = 0; WR = 0; FETCH = 0; MEM_RDATA = '0; MEM_BDATA = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    #12;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    m_mar = 0; m_mdr = 0; m_pc = 0; m_sp = 0; m_lv = 0; m_cpp = 0; m_tos = 0;
    m_opc = 0; m_h = 0; m_mbr = 0; m_n = 0; m_z = 0; m_conf = 0; pend_cmd = 0;
  endtask

  function automatic logic [31:0] model_b(input int sel);
    case (sel)
      0: return m_mdr;
      1: return m_pc;
      2: return {{24{m_mbr[7]}}, m_mbr};
      3: return {24'h0, m_mbr};
      4: return m_sp;
      5: return m_lv;
      6: return m_cpp;
      7: return m_tos;
      8: return m_opc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    logic [2:0] cmds;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      B_SEL = 4'(s);
      #1;
      n_cmp++;
      if (B_out !== 32'h0) begin
        n_err++;
        $display("FAIL reset_b_out sel=%0d got=%h exp=%h", s, B_out, 32'h0);
      end
    end
    cmds = {MEM_FETCH, MEM_WR, MEM_RD};
    n_cmp++;
    if ({A_out, MEM_ADDR, FETCH_ADDR, MEM_WDATA} !== 128'h0 || cmds !== 3'b000 ||
        {N_FLAG, Z_FLAG, MDR_CONFLICT} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_state got A=%h ADDR=%h PC=%h WD=%h cmd=%b flags=%b exp all zero",
               A_out, MEM_ADDR, FETCH_ADDR, MEM_WDATA, cmds, {N_FLAG, Z_FLAG, MDR_CONFLICT});
    end
  endtask

  task automatic test_h_write();
    do_reset();
    C_SEL = 9'h100; Shift = 32'hAAAAAAAA;
    tick();
    idle_inputs();
    n_cmp++;
    if (A_out !== 32'hAAAAAAAA) begin
      n_err++;
      $display("FAIL h_write_a got=%h exp=%h", A_out, 32'hAAAAAAAA);
    end
    for (int s = 0; s < 9; s++) begin
      B_SEL = 4'(s);
      #1;
      n_cmp++;
      if (B_out !== 32'h0) begin
        n_err++;
        $display("FAIL h_write_others sel=%0d got=%h exp=%h", s, B_out, 32'h0);
      end
    end
    n_cmp++;
    if ({MEM_ADDR, FETCH_ADDR, MEM_WDATA} !== 96'h0) begin
      n_err++;
      $display("FAIL h_write_mem got=%h/%h/%h exp=0", MEM_ADDR, FETCH_ADDR, MEM_WDATA);
    end
  endtask

  task automatic test_mbr_ext();
    FETCH = 1'b1;
    tick();
    FETCH = 1'b0; MEM_BDATA = 8'h80;
    n_cmp++;
    if (MEM_FETCH !== 1'b1) begin
      n_err++;
      $display("FAIL mbr_mem_fetch got=%b exp=%b", MEM_FETCH, 1'b1);
    end
    tick();
    MEM_BDATA = 8'h00;
    B_SEL = 4'd2; #1;
    n_cmp++;
    if (B_out !== 32'hFFFFFF80) begin
      n_err++;
      $display("FAIL mbr_sext got=%h exp=%h", B_out, 32'hFFFFFF80);
    end
    B_SEL = 4'd3; #1;
    n_cmp++;
    if (B_out !== 32'h00000080) begin
      n_err++;
      $display("FAIL mbr_zext got=%h exp=%h", B_out, 32'h00000080);
    end
    B_SEL = 4'd12; #1;
    n_cmp++;
    if (B_out !== 32'h0) begin
      n_err++;
      $display("FAIL bsel_unused got=%h exp=%h", B_out, 32'h0);
    end
  endtask

  task automatic test_read();
    C_SEL = 9'h001; Shift = 32'h10; RD = 1'b1;
    tick();
    C_SEL = '0; Shift = '0; RD = 1'b0; MEM_RDATA = 32'hD5555555;
    n_cmp++;
    if (MEM_ADDR !== 32'h10 || MEM_RD !== 1'b1) begin
      n_err++;
      $display("FAIL read_issue got addr=%h rd=%b exp addr=%h rd=1", MEM_ADDR, MEM_RD, 32'h10);
    end
    tick();
    MEM_RDATA = '0;
    B_SEL = 4'd0; #1;
    n_cmp++;
    if (B_out !== 32'hD5555555 || MEM_RD !== 1'b0) begin
      n_err++;
      $display("FAIL read_data got=%h rd=%b exp=%h rd=0", B_out, MEM_RD, 32'hD5555555);
    end
  endtask

  task automatic test_back_to_back();
    RD = 1'b1; FETCH = 1'b1;
    tick();
    MEM_RDATA = 32'h11112222; MEM_BDATA = 8'h7F;
    tick();
    RD = 1'b0; FETCH = 1'b0;
    n_cmp++;
    if (MEM_WDATA !== 32'h11112222 || dut.mbr_q !== 8'h7F) begin
      n_err++;
      $display("FAIL b2b_first got mdr=%h mbr=%h exp mdr=%h mbr=%h",
               MEM_WDATA, dut.mbr_q, 32'h11112222, 8'h7F);
    end
    MEM_RDATA = 32'h33334444; MEM_BDATA = 8'h01;
    tick();
    B_SEL = 4'd3; #1;
    n_cmp++;
    if (MEM_WDATA !== 32'h33334444 || B_out !== 32'h1) begin
      n_err++;
      $display("FAIL b2b_second got mdr=%h mbr=%h exp mdr=%h mbr=%h",
               MEM_WDATA, B_out, 32'h33334444, 32'h1);
    end
    idle_inputs();
  endtask

  task automatic test_conflict();
    RD = 1'b1;
    tick();
    RD = 1'b0; C_SEL = 9'h002; Shift = 32'h1234; MEM_RDATA = 32'hCAFEF00D;
    tick();
    idle_inputs();
    n_cmp++;
    if (MEM_WDATA !== 32'hCAFEF00D || MDR_CONFLICT !== 1'b1) begin
      n_err++;
      $display("FAIL conflict got mdr=%h pulse=%b exp mdr=%h pulse=1",
               MEM_WDATA, MDR_CONFLICT, 32'hCAFEF00D);
    end
    tick();
    n_cmp++;
    if (MDR_CONFLICT !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_end got=%b exp=%b", MDR_CONFLICT, 1'b0);
    end
  endtask

  task automatic test_reset_inflight();
    RD = 1'b1;
    tick();
    RD = 1'b0; MEM_RDATA = 32'hFFFF0000;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (MEM_RD !== 1'b0 || MEM_WDATA !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset got rd=%b mdr=%h exp rd=0 mdr=0", MEM_RD, MEM_WDATA);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
    n_cmp++;
    if (MEM_WDATA !== 32'h0) begin
      n_err++;
      $display("FAIL late_load got=%h exp=%h", MEM_WDATA, 32'h0);
    end
    idle_inputs();
  endtask

  task automatic test_flags();
    ALU_N = 1'b1; ALU_Z = 1'b0;
    tick();
    n_cmp++;
    if ({N_FLAG, Z_FLAG} !== 2'b10) begin
      n_err++;
      $display("FAIL flags_n got=%b exp=%b", {N_FLAG, Z_FLAG}, 2'b10);
    end
    ALU_N = 1'b0; ALU_Z = 1'b1;
    tick();
    n_cmp++;
    if ({N_FLAG, Z_FLAG} !== 2'b01) begin
      n_err++;
      $display("FAIL flags_z got=%b exp=%b", {N_FLAG, Z_FLAG}, 2'b01);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [2:0]  cmd;
    logic [31:0] v;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      Shift     = $urandom;
      C_SEL     = 9'($urandom) & 9'($urandom);
      B_SEL     = 4'($urandom);
      ALU_N     = 1'($urandom);
      ALU_Z     = 1'($urandom);
      RD        = ($urandom_range(0, 2) == 0);
      WR        = ($urandom_range(0, 3) == 0);
      FETCH     = ($urandom_range(0, 2) == 0);
      MEM_RDATA = $urandom;
      MEM_BDATA = 8'($urandom);
      v = Shift;
      // Model: C-bus targets by name, then memory returns for last cycle's commands
      m_conf = pend_cmd[0] && C_SEL[1];
      if (C_SEL[0]) m_mar = v;
      if (C_SEL[1]) m_mdr = v;
      if (C_SEL[2]) m_pc  = v;
      if (C_SEL[3]) m_sp  = v;
      if (C_SEL[4]) m_lv  = v;
      if (C_SEL[5]) m_cpp = v;
      if (C_SEL[6]) m_tos = v;
      if (C_SEL[7]) m_opc = v;
      if (C_SEL[8]) m_h   = v;
      if (pend_cmd[0]) m_mdr = MEM_RDATA;
      if (pend_cmd[2]) m_mbr = MEM_BDATA;
      m_n = ALU_N;
      m_z = ALU_Z;
      pend_cmd = {FETCH, WR, RD};
      tick();
      n_cmp++;
      if (B_out !== model_b(int'(B_SEL))) begin
        n_err++;
        $display("FAIL rand_b cyc=%0d sel=%0d got=%h exp=%h", cyc, B_SEL, B_out,
                 model_b(int'(B_SEL)));
      end
      n_cmp++;
      if (A_out !== m_h || MEM_ADDR !== m_mar || FETCH_ADDR !== m_pc || MEM_WDATA !== m_mdr) begin
        n_err++;
        $display("FAIL rand_regs cyc=%0d got %h/%h/%h/%h exp %h/%h/%h/%h", cyc, A_out,
                 MEM_ADDR, FETCH_ADDR, MEM_WDATA, m_h, m_mar, m_pc, m_mdr);
      end
      cmd = {MEM_FETCH, MEM_WR, MEM_RD};
      n_cmp++;
      if (cmd !== pend_cmd || {N_FLAG, Z_FLAG, MDR_CONFLICT} !== {m_n, m_z, m_conf}) begin
        n_err++;
        $display("FAIL rand_ctrl cyc=%0d got cmd=%b nzc=%b exp cmd=%b nzc=%b", cyc, cmd,
                 {N_FLAG, Z_FLAG, MDR_CONFLICT}, pend_cmd, {m_n, m_z, m_conf});
      end
    end
    idle_inputs();
  endtask

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    test_reset();
    test_h_write();
    test_mbr_ext();
    test_read();
    test_back_to_back();
    test_conflict();
    test_reset_inflight();
    test_flags();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
